// File: rtl/dmem_responder_pkg.sv
// Shared types and size encodings for the data-memory responder.
// The size encodings are also used by the store-pattern logic upstream.
package dmem_responder_pkg;

    localparam int XLEN      = 32;
    localparam int ADDR_SIZE = 32;

    localparam logic [1:0] MEM_SIZE_W = 2'b01;
    localparam logic [1:0] MEM_SIZE_H = 2'b10;
    localparam logic [1:0] MEM_SIZE_B = 2'b11;
    localparam int         SIZE_UNSIGNED_BIT = 2;

    typedef struct packed {
        logic                 we;
        logic [ADDR_SIZE-1:0] addr;
        logic [3:0]           amp;
        logic [XLEN-1:0]      wdata;
        logic [2:0]           size;
    } dmem_req_t;

    // Illegal size code or an address not aligned to the access width.
    function automatic logic size_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size[1:0])
            MEM_SIZE_W: bad = (addr_lo != 2'b00);
            MEM_SIZE_H: bad = addr_lo[0];
            MEM_SIZE_B: bad = 1'b0;
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_responder_ldext.sv
// Load lane selection and sign/zero extension of a 32-bit storage word.
module ldext
    import dmem_responder_pkg::*;
(
    input  logic [XLEN-1:0] word_i,
    input  logic [1:0]      addr_i,
    input  logic [2:0]      size_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic        sext_s;

    // Pick the addressed lane(s) and widen to XLEN.
    always_comb begin
        byte_s = word_i[{addr_i, 3'b000} +: 8];
        half_s = addr_i[1] ? word_i[31:16] : word_i[15:0];
        sext_s = ~size_i[SIZE_UNSIGNED_BIT];
        case (size_i[1:0])
            MEM_SIZE_W: data_o = word_i;
            MEM_SIZE_H: data_o = {{16{sext_s & half_s[15]}}, half_s};
            MEM_SIZE_B: data_o = {{24{sext_s & byte_s[7]}}, byte_s};
            default:    data_o = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-port data memory behind a valid/ready request/response handshake
// with a programmable number of access cycles.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [3:0]           req_amp,
    input  logic [XLEN-1:0]      req_wdata,
    input  logic [2:0]           req_size,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [XLEN-1:0]      resp_rdata,
    output logic                 resp_err
);

    localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    dmem_req_t       req_q, req_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [XLEN-1:0] mem_q [DEPTH_WORDS];

    logic [IDX_W-1:0] idx_s;
    logic [XLEN-1:0]  word_s;
    logic [XLEN-1:0]  ld_data_s;
    logic             misalign_s;
    logic             last_s;
    logic             wr_en_s;
    logic             unused_addr_s;

    assign idx_s         = req_q.addr[IDX_W+1:2];
    assign word_s        = mem_q[idx_s];
    assign misalign_s    = size_misaligned(req_q.size, req_q.addr[1:0]);
    assign last_s        = (state_q == ST_ACCESS) && (cnt_q == 4'd0);
    assign wr_en_s       = last_s & req_q.we & ~misalign_s;
    assign unused_addr_s = ^{1'b0, req_q.addr[ADDR_SIZE-1:IDX_W+2]};

    ldext u_ldext (
        .word_i (word_s),
        .addr_i (req_q.addr[1:0]),
        .size_i (req_q.size),
        .data_o (ld_data_s)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            rdata_q <= {XLEN{1'b0}};
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = req_valid ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: state_d = (cnt_q == 4'd0) ? ST_RESP : ST_ACCESS;
            ST_RESP:   state_d = resp_ready ? ST_IDLE : ST_RESP;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Request capture, wait countdown and response formation on the last access cycle.
    always_comb begin
        cnt_d   = cnt_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    cnt_d = CNT_LOAD;
                    req_d = '{we: req_we, addr: req_addr, amp: req_amp,
                              wdata: req_wdata, size: req_size};
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    err_d   = misalign_s;
                    rdata_d = (misalign_s | req_q.we) ? {XLEN{1'b0}} : ld_data_s;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: cnt_d = cnt_q;
            default: cnt_d = 4'd0;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        resp_valid = (state_q == ST_RESP);
        resp_rdata = rdata_q;
        resp_err   = err_q;
    end

    // Storage is never reset; a store commits only its enabled lanes.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int i = 0; i < 4; i++) begin
                if (req_q.amp[i]) begin
                    mem_q[idx_s][8*i +: 8] <= req_q.wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, is the number of 32-bit storage words; its index is addr[log2(DEPTH_WORDS)+1:2].
REQ-002 Parameter WAIT_CYCLES, default 1, is the number of access cycles per request (1..15).
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  responder can accept a request.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_addr  in  `ADDR_SIZE  byte address.
REQ-009 req_amp  in  4  store byte-enable pattern (bit i = byte lane i).
REQ-010 req_wdata  in  `XLEN  store data, lane-aligned.
REQ-011 req_size  in  3  [1:0] 01 word, 10 half, 11 byte; [2] 1 = zero-extend load.
REQ-012 resp_valid  out  1  response present.
REQ-013 resp_ready  in  1  consumer accepts the response.
REQ-014 resp_rdata  out  `XLEN  extended load data; 0 for stores and errors.
REQ-015 resp_err  out  1  misaligned or illegal-size access.

Function
REQ-016 The FSM SHALL have the states IDLE, ACCESS and RESP; req_ready=1 only in IDLE; resp_valid=1 only in RESP.
REQ-017 IDLE SHALL go to ACCESS when req_valid=1, latching we, addr, amp, wdata and size, and loading the wait counter with WAIT_CYCLES-1.
REQ-018 ACCESS SHALL decrement the counter each cycle and go to RESP in the cycle after it reads 0; minimum request-to-resp_valid latency is WAIT_CYCLES+1 cycles.
REQ-019 On leaving ACCESS, a store SHALL write only the lanes whose amp bit is set, and a load SHALL register the extended data into resp_rdata.
REQ-020 Load extension: byte selects lane addr[1:0], half selects lane pair addr[1], word uses all lanes; the result is sign- or zero-extended per size[2].
REQ-021 Misaligned accesses (half with addr[0]=1, word with addr[1:0]!=0) and size=00 SHALL set resp_err=1 with resp_rdata=0 and SHALL perform no write.
REQ-022 RESP SHALL hold resp_valid, resp_rdata and resp_err stable until resp_ready=1, then go to IDLE; back-to-back throughput is one request per WAIT_CYCLES+2 cycles.
REQ-023 req_valid arriving while the FSM is not in IDLE SHALL be ignored and not queued; the requester holds it until it sees req_ready.
REQ-024 Addresses beyond DEPTH_WORDS SHALL wrap modulo the depth; upper address bits are ignored.
REQ-025 A load from a location written earlier SHALL return the new data (a sequential store then load gives read-after-write).

Reset
REQ-026 Reset SHALL force state=IDLE, counter=0, resp_valid=0, resp_rdata=0 and resp_err=0; req_ready SHALL be 1 from the first cycle after reset deasserts.
REQ-027 Reset during ACCESS SHALL abandon the request with no write; reset during RESP SHALL drop the response.
REQ-028 Storage contents SHALL NOT be reset.

Structure
REQ-029 The size encodings (MEM_SIZE_W=01, MEM_SIZE_H=10, MEM_SIZE_B=11, bit 2 = unsigned) SHALL be defined in xgriscv_defines.v and shared with the store-pattern logic.
REQ-030 Load lane selection and extension SHALL be one combinational sub-module, ldext (inputs: word, addr[1:0], size; output: `XLEN data).
REQ-031 The FSM state encoding SHALL be local constants inside dmem_responder.

Verification
REQ-032 Store word 0xDEADBEEF at 0x10 with amp=1111, then load word 0x10 -> resp_rdata=0xDEADBEEF, resp_err=0.
REQ-033 After REQ-032, load signed byte 0x13 -> 0xFFFFFFDE; load unsigned byte 0x13 -> 0x000000DE; load signed half 0x10 -> 0xFFFFBEEF.
REQ-034 Store 0x00AA0000 with amp=0100 at 0x10, then load word 0x10 -> 0xDEAABEEF.
REQ-035 Load word 0x12 -> resp_err=1, resp_rdata=0; a following load of 0x10 returns unchanged data.
REQ-036 WAIT_CYCLES=3, resp_ready held 0 for 5 cycles -> resp_valid first high 4 cycles after acceptance, outputs stable throughout, req_ready=0 until the handshake completes.
REQ-037 Assert reset during the ACCESS of a store of 0x12345678 to 0x20 -> the FSM is in IDLE with resp_valid=0, and a later load of 0x20 returns the prior contents.
